// File: rtl/stepper_seq.sv
// stepper_seq: sequencer for a unipolar 4-coil stepper motor.
// It accepts a move command (steps, direction, drive mode, step period) and
// walks an 8-entry half-step phase table.
// The phase index p and the signed position carry over from one move to the next.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only while the sequencer is idle. The command fields must be
// stable while cmd_valid is high, and they are sampled only on the transfer edge.
module stepper_seq #(
  parameter int PER_W = 32,
  parameter int CNT_W = 16,
  parameter int POS_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [1:0]       cmd_mode,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             hold_en,
  input  logic             stop,
  output logic [3:0]       coil,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WAVE = 2'b10;

  state_t           state, state_nxt;
  logic [2:0]       p;
  logic [2:0]       p_nxt;
  logic [2:0]       stride;
  logic [CNT_W-1:0] rem;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] per_r;
  logic             dir_r;
  logic [1:0]       mode_r;
  logic             abort_r;
  logic [POS_W-1:0] pos_r;
  logic             step_now;
  logic             end_abort;
  logic             accept;

  // Coil pattern for each phase index, as {IN4,IN3,IN2,IN1}.
  function automatic logic [3:0] phase_coil(input logic [2:0] idx);
    logic [3:0] c;
    case (idx)
      3'd0:    c = 4'b0101;
      3'd1:    c = 4'b0001;
      3'd2:    c = 4'b1001;
      3'd3:    c = 4'b1000;
      3'd4:    c = 4'b1010;
      3'd5:    c = 4'b0010;
      3'd6:    c = 4'b0110;
      default: c = 4'b0100;
    endcase
    return c;
  endfunction

  assign accept = cmd_valid && (state == S_IDLE);

  // Next phase index.
  // Full-step settles on even phases and wave settles on odd phases. A misaligned
  // start therefore takes a single 1-phase hop first.
  always_comb begin
    stride = 3'd1;
    if (mode_r == MODE_HALF) begin
      stride = 3'd1;
    end else if (mode_r == MODE_WAVE) begin
      stride = p[0] ? 3'd2 : 3'd1;
    end else begin
      stride = p[0] ? 3'd1 : 3'd2;
    end
    p_nxt = dir_r ? (p - stride) : (p + stride);
  end

  // Next-state logic. In RUN, stop takes priority over a step due on the same cycle.
  always_comb begin
    state_nxt = state;
    step_now  = 1'b0;
    end_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_END;
          end_abort = 1'b1;
        end else if (rem == '0) begin
          state_nxt = S_END;
        end else if (cnt == per_r - PER_W'(1)) begin
          step_now = 1'b1;
          if (rem == CNT_W'(1)) state_nxt = S_END;
        end
      end
      S_END: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Command latch, period timer, phase and position update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p       <= 3'd0;
      rem     <= '0;
      cnt     <= '0;
      per_r   <= PER_W'(2);
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
      abort_r <= 1'b0;
      pos_r   <= '0;
    end else begin
      if (accept) begin
        rem     <= cmd_steps;
        dir_r   <= cmd_dir;
        mode_r  <= cmd_mode;
        per_r   <= (cmd_period < PER_W'(2)) ? PER_W'(2) : cmd_period;
        cnt     <= '0;
        abort_r <= 1'b0;
      end else if (state == S_RUN) begin
        if (state_nxt == S_END) abort_r <= end_abort;
        if (!stop && rem != '0) begin
          if (step_now) begin
            cnt   <= '0;
            p     <= p_nxt;
            rem   <= rem - CNT_W'(1);
            pos_r <= dir_r ? (pos_r - POS_W'(1)) : (pos_r + POS_W'(1));
          end else begin
            cnt <= cnt + PER_W'(1);
          end
        end
      end
    end
  end

  // Outputs.
  // The coil is also gated by the reset pin, so the drivers drop as soon as
  // reset asserts, even when holding current is requested.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state == S_RUN) || (state == S_END);
    done      = (state == S_END);
    aborted   = (state == S_END) && abort_r;
    position  = pos_r;
    dbg_state = state;
    if (!rst || (state == S_IDLE && !hold_en)) coil = 4'b0000;
    else                                       coil = phase_coil(p);
  end

endmodule
